// File: rtl/rcv_cfg_if.sv
// rcv_cfg_if: received-word handshake between the serial receiver (master) and its consumer (slave).
interface rcv_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic valid;
  logic ready;
  logic parity_err;
  logic frame_err;
  logic overrun;
  modport master(output data_out, valid, parity_err, frame_err, overrun, input ready);
  modport slave(input data_out, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/rcv_cfg.sv
// rcv_cfg: configurable UART receiver with majority voting, error flags and a one-word holding register.
module rcv_cfg #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic reset,
  input logic serial_in,
  rcv_cfg_if.master bus
);
  localparam int cw = $clog2(CLKS_PER_BIT);
  localparam logic [cw-1:0] half = cw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [cw-1:0] full = cw'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, COMMIT, BRK} state_t;
  state_t st;
  logic s1, serial_s, pe, fe, maj, tick;
  logic [2:0] hist;
  logic [cw-1:0] cnt;
  logic [3:0] fld;
  logic [DATA_BITS-1:0] sh;
  assign maj = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign tick = cnt == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      serial_s <= 1'b1;
      hist <= 3'b111;
      cnt <= '0;
      fld <= '0;
      sh <= '0;
      pe <= 1'b0;
      fe <= 1'b0;
      st <= IDLE;
      bus.data_out <= '0;
      bus.valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      s1 <= serial_in;
      serial_s <= s1;
      hist <= {hist[1:0], serial_s};
      cnt <= tick ? cnt : cnt - 1'b1;
      if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
        bus.overrun <= 1'b0;
      end
      case (st)
        IDLE: if (!serial_s) begin
          st <= START;
          cnt <= half;
        end
        START: if (tick) begin
          st <= maj ? IDLE : DATA;
          cnt <= full;
          fld <= '0;
          pe <= 1'b0;
          fe <= 1'b0;
        end
        DATA: if (tick) begin
          sh <= {maj, sh[DATA_BITS-1:1]};
          cnt <= full;
          fld <= (fld == 4'(DATA_BITS - 1)) ? 4'd0 : fld + 4'd1;
          st <= (fld != 4'(DATA_BITS - 1)) ? DATA : (PARITY != 0) ? PAR : STOP;
        end
        PAR: if (tick) begin
          pe <= ^sh ^ maj ^ 1'(PARITY == 1);
          cnt <= full;
          st <= STOP;
        end
        STOP: if (tick) begin
          fe <= fe | ~maj;
          cnt <= full;
          fld <= fld + 4'd1;
          st <= (fld == 4'(STOP_BITS - 1)) ? COMMIT : STOP;
        end
        COMMIT: begin
          // A full, unconsumed holding register keeps its word; the new frame is dropped.
          if (!bus.valid || bus.ready) begin
            bus.data_out <= sh;
            bus.parity_err <= pe;
            bus.frame_err <= fe;
            bus.valid <= 1'b1;
          end else begin
            bus.overrun <= 1'b1;
          end
          st <= fe ? BRK : IDLE;
        end
        BRK: if (serial_s) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rcv_cfg.sv
// tb_rcv_cfg: four receiver configurations driven by directed and random frames, checked against a frame-level model.
module tb_rcv_cfg;
  localparam int CPB = 16;
  localparam int NU = 4;
  int db [NU] = '{8, 7, 8, 8};
  int pm [NU] = '{0, 2, 0, 1};
  int sb [NU] = '{1, 1, 2, 1};
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic ser [NU];
  logic rdy [NU];
  rcv_cfg_if #(.DATA_BITS(8)) b0();
  rcv_cfg_if #(.DATA_BITS(7)) b1();
  rcv_cfg_if #(.DATA_BITS(8)) b2();
  rcv_cfg_if #(.DATA_BITS(8)) b3();
  assign b0.ready = rdy[0];
  assign b1.ready = rdy[1];
  assign b2.ready = rdy[2];
  assign b3.ready = rdy[3];
  rcv_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .reset(reset), .serial_in(ser[0]), .bus(b0.master));
  rcv_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (.clk(clk), .reset(reset), .serial_in(ser[1]), .bus(b1.master));
  rcv_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (.clk(clk), .reset(reset), .serial_in(ser[2]), .bus(b2.master));
  rcv_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u3 (.clk(clk), .reset(reset), .serial_in(ser[3]), .bus(b3.master));
  // Per unit: {valid, overrun, parity_err, frame_err, data (zero-extended to 8)}
  logic [11:0] dv [NU];
  assign dv[0] = {b0.valid, b0.overrun, b0.parity_err, b0.frame_err, b0.data_out};
  assign dv[1] = {b1.valid, b1.overrun, b1.parity_err, b1.frame_err, 1'b0, b1.data_out};
  assign dv[2] = {b2.valid, b2.overrun, b2.parity_err, b2.frame_err, b2.data_out};
  assign dv[3] = {b3.valid, b3.overrun, b3.parity_err, b3.frame_err, b3.data_out};
  typedef struct {
    int at;
    int u;
    logic [7:0] d;
    logic pe;
    logic fe;
  } ev_t;
  ev_t q [$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic mv [NU], mo [NU], mpe [NU], mfe [NU], pv [NU];
  logic [7:0] md [NU];
  int rise [NU], vcnt [NU];
  // Holding-register model: a frame commits at a known edge, then the commit/transfer rules apply.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      for (int u = 0; u < NU; u++) begin
        mv[u] = 1'b0; mo[u] = 1'b0; mpe[u] = 1'b0; mfe[u] = 1'b0; md[u] = 8'h00;
      end
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (q.size() > 0 && q[0].at == cyc && q[0].u == u) begin
          if (!mv[u] || rdy[u]) begin
            md[u] = q[0].d; mpe[u] = q[0].pe; mfe[u] = q[0].fe; mv[u] = 1'b1; mo[u] = 1'b0;
          end else begin
            mo[u] = 1'b1;
          end
          void'(q.pop_front());
        end else if (mv[u] && rdy[u]) begin
          mv[u] = 1'b0; mo[u] = 1'b0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int u = 0; u < NU; u++) begin
        tests++;
        if (dv[u] !== {mv[u], mo[u], mpe[u], mfe[u], md[u]}) begin
          fails++;
          if (fails < 30) $display("FAIL model_cmp u%0d cyc %0d got %h want %h", u, cyc, dv[u], {mv[u], mo[u], mpe[u], mfe[u], md[u]});
        end
        if (dv[u][11] && !pv[u]) rise[u] = cyc;
        if (dv[u][11]) vcnt[u]++;
        pv[u] = dv[u][11];
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // rmode: 0 leave ready, 1 random ready, 2 ready only in the commit cycle. abort: bit-time offset to reset at.
  task automatic send(input int u, input logic [7:0] din, input bit flip, input logic [1:0] stp,
                      input int glitch, input int rmode, input int abort);
    logic bits [$];
    logic [7:0] d;
    logic pb, pe, fe;
    int at;
    d = din & 8'((1 << db[u]) - 1);
    bits.push_back(1'b0);
    for (int i = 0; i < db[u]; i++) bits.push_back(d[i]);
    pb = ((pm[u] == 1) ? ~^d : ^d) ^ flip;
    pe = 1'b0;
    if (pm[u] != 0) begin
      bits.push_back(pb);
      pe = flip;
    end
    fe = 1'b0;
    for (int s = 0; s < sb[u]; s++) begin
      bits.push_back(stp[s]);
      fe = fe | ~stp[s];
    end
    at = cyc + 4 + CPB / 2 + (bits.size() - 1) * CPB;
    q.push_back('{at, u, d, pe, fe});
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b * CPB + c == abort) begin
          reset = 1'b1;
          ser[u] = 1'b1;
          idle(3);
          reset = 1'b0;
          return;
        end
        ser[u] = (b * CPB + c == glitch) ? ~bits[b] : bits[b];
        if (rmode == 1) rdy[u] = 1'($urandom_range(0, 1));
        else if (rmode == 2) rdy[u] = (cyc + 1 == at);
        @(negedge clk);
      end
    end
  endtask
  initial begin
    int t0;
    logic [1:0] stp;
    for (int u = 0; u < NU; u++) begin
      ser[u] = 1'b1; rdy[u] = 1'b0; pv[u] = 1'b0; rise[u] = 0; vcnt[u] = 0;
      mv[u] = 1'b0; mo[u] = 1'b0; mpe[u] = 1'b0; mfe[u] = 1'b0; md[u] = 8'h00;
    end
    idle(4);
    reset = 1'b0;
    for (int u = 0; u < NU; u++) chk($sformatf("reset_u%0d", u), 32'(dv[u]), 32'h0);
    rdy[0] = 1'b1;
    idle(5);
    vcnt[0] = 0;
    t0 = cyc;
    send(0, 8'hA5, 1'b0, 2'b11, -1, 0, -1);
    idle(4);
    chk("a5_rise", rise[0], t0 + 156);
    chk("a5_pulse", vcnt[0], 1);
    chk("a5_data", 32'(dv[0][7:0]), 32'hA5);
    chk("a5_flags", 32'(dv[0][11:8]), 32'h0);
    rdy[1] = 1'b1;
    send(1, 8'h41, 1'b0, 2'b11, -1, 0, -1);
    idle(4);
    chk("7e1_pe0", 32'(b1.parity_err), 32'h0);
    send(1, 8'h41, 1'b1, 2'b11, -1, 0, -1);
    idle(4);
    chk("7e1_pe1", 32'(b1.parity_err), 32'h1);
    chk("7e1_data", 32'(b1.data_out), 32'h41);
    rdy[3] = 1'b1;
    send(3, 8'h01, 1'b0, 2'b11, -1, 0, -1);
    idle(4);
    chk("8o1_pe0", 32'(b3.parity_err), 32'h0);
    send(3, 8'h01, 1'b1, 2'b11, -1, 0, -1);
    idle(4);
    chk("8o1_pe1", 32'(b3.parity_err), 32'h1);
    rdy[2] = 1'b1;
    send(2, 8'h5A, 1'b0, 2'b01, -1, 0, -1);
    idle(40 * CPB);
    chk("8n2_fe1", 32'(b2.frame_err), 32'h1);
    chk("8n2_data", 32'(b2.data_out), 32'h5A);
    ser[2] = 1'b1;
    idle(CPB);
    send(2, 8'h3C, 1'b0, 2'b11, -1, 0, -1);
    idle(4);
    chk("8n2_fe0", 32'(b2.frame_err), 32'h0);
    chk("8n2_next", 32'(b2.data_out), 32'h3C);
    vcnt[0] = 0;
    ser[0] = 1'b0;
    idle(3);
    ser[0] = 1'b1;
    idle(3 * CPB);
    chk("glitch_novalid", vcnt[0], 0);
    send(0, 8'h00, 1'b0, 2'b11, 4 * CPB + 6, 0, -1);
    idle(4);
    chk("spike_data", 32'(dv[0][7:0]), 32'h00);
    chk("spike_valid_seen", vcnt[0], 1);
    rdy[0] = 1'b0;
    idle(2);
    send(0, 8'h11, 1'b0, 2'b11, -1, 0, -1);
    send(0, 8'h22, 1'b0, 2'b11, -1, 0, -1);
    idle(4);
    chk("ovr_data", 32'(dv[0][7:0]), 32'h11);
    chk("ovr_flag", 32'(dv[0][11:10]), 32'h3);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    chk("ovr_cleared", 32'(dv[0][11:10]), 32'h0);
    send(0, 8'h11, 1'b0, 2'b11, -1, 0, -1);
    send(0, 8'h33, 1'b0, 2'b11, -1, 0, -1);
    send(0, 8'h22, 1'b0, 2'b11, -1, 2, -1);
    idle(4);
    chk("commit_xfer_data", 32'(dv[0][7:0]), 32'h22);
    chk("commit_xfer_flags", 32'(dv[0][11:10]), 32'h2);
    rdy[0] = 1'b1;
    idle(2);
    vcnt[0] = 0;
    send(0, 8'h7E, 1'b0, 2'b11, -1, 0, 5 * CPB + 3);
    idle(3 * CPB);
    chk("abort_novalid", vcnt[0], 0);
    chk("abort_state", 32'(dv[0]), 32'h0);
    send(0, 8'h81, 1'b0, 2'b11, -1, 0, -1);
    idle(4);
    chk("after_reset_data", 32'(dv[0][7:0]), 32'h81);
    for (int u = 0; u < NU; u++) begin
      for (int n = 0; n < 25; n++) begin
        stp = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
        send(u, 8'($urandom), (pm[u] != 0) && ($urandom_range(0, 3) == 0), stp, -1, 1, -1);
        if (stp[0] == 1'b0 || (sb[u] == 2 && stp[1] == 1'b0)) begin
          ser[u] = 1'b1;
          idle(3 * CPB);
        end else if ($urandom_range(0, 3) == 0) begin
          idle($urandom_range(1, 40));
        end
      end
      rdy[u] = 1'b1;
      idle(2 * CPB);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
